// File: rtl/sar_pkg.sv
// sar_pkg: shared definitions for the successive-approximation controller.
//   - sar_state_e       : controller FSM states
//   - DEF_WIDTH         : default conversion resolution
//   - DEF_SAMPLE_CYCLES : default sample/hold window in clk cycles
//   - cnt_width / ptr_width : register widths for the sample counter and
//                             the bit pointer, never narrower than one bit
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_e;

    localparam int DEF_WIDTH         = 8;
    localparam int DEF_SAMPLE_CYCLES = 2;

    // Counter runs 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Pointer holds bit indices w-1..0.
    function automatic int ptr_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/sar_controller.sv
// sar_controller: SAR ADC sequencer. Closes the sample switch for
// SAMPLE_CYCLES cycles, then resolves one bit per cycle, MSB first, using
// the comparator decision, and pulses done with the final code.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active low
//   start    : conversion request, only honoured in IDLE
//   comp     : comparator, 1 = Vin >= DAC(dac_code)
//   sample   : sample/hold switch enable
//   dac_code : trial code to the capacitive DAC (0 outside CONVERT)
//   busy     : high whenever not IDLE
//   done     : one-cycle pulse, result valid during it
//   result   : last completed conversion, held until the next one ends
module sar_controller
    import sar_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             comp,
    output logic             sample,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = cnt_width(SAMPLE_CYCLES);
    localparam int PTR_W = ptr_width(WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_MSB  = PTR_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MASK_MSB = {1'b1, {(WIDTH-1){1'b0}}};

    sar_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] sar_q, sar_d;      // bits already decided
    logic [WIDTH-1:0] mask_q, mask_d;    // one-hot: bit under trial
    logic             sample_q, sample_d;
    logic [WIDTH-1:0] dac_q, dac_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] decided;

    // Outputs are the next-state values registered, so every output is a
    // flop and neither start nor comp reaches a pin combinationally.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        sar_d    = sar_q;
        mask_d   = mask_q;
        sample_d = sample_q;
        dac_d    = dac_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        // Keep the trial bit only when Vin is at or above the trial level.
        decided  = comp ? (sar_q | mask_q) : sar_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SAMPLE;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                end
            end
            SAMPLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = CONVERT;
                    sample_d = 1'b0;
                    ptr_d    = PTR_MSB;
                    mask_d   = MASK_MSB;
                    sar_d    = '0;
                    dac_d    = MASK_MSB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CONVERT: begin
                sar_d = decided;
                if (ptr_q == '0) begin
                    state_d  = DONE;
                    result_d = decided;
                    done_d   = 1'b1;
                    dac_d    = '0;
                end else begin
                    ptr_d  = ptr_q - PTR_W'(1);
                    mask_d = mask_q >> 1;
                    dac_d  = decided | (mask_q >> 1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                sample_d = 1'b0;
                dac_d    = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ptr_q    <= PTR_MSB;
            sar_q    <= '0;
            mask_q   <= '0;
            sample_q <= 1'b0;
            dac_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            sar_q    <= sar_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            dac_q    <= dac_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign sample   = sample_q;
    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: self-checking bench for sar_controller (WIDTH=8,
// SAMPLE_CYCLES=2). An ideal comparator closes the loop against vin; the
// expected code of every started conversion is queued and checked when
// done pulses.
module tb_sar_controller;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       comp;
    logic       sample;
    logic       busy;
    logic       done;
    logic [7:0] dac_code;
    logic [7:0] result;
    logic [7:0] vin   = 8'h00;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    assign comp = (vin >= dac_code);

    sar_controller #(.WIDTH(8), .SAMPLE_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .comp     (comp),
        .sample   (sample),
        .dac_code (dac_code),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Scoreboard consumer: every done must match the oldest queued code.
    always @(negedge clk) begin
        logic [7:0] e;
        if (done === 1'b1) begin
            done_cnt++;
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_done: result=%h, required no done pulse", result);
            end else begin
                e = sb.pop_front();
                if (result !== e) begin
                    n_err++;
                    $display("FAIL sb_result: got %h, required %h", result, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic test_reset;
        #12;
        n_vec++;
        if ({sample, busy, done} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: sample/busy/done=%b, required 000", {sample, busy, done});
        end
        n_vec++;
        if (dac_code !== 8'h00 || result !== 8'h00) begin
            n_err++;
            $display("FAIL reset_data: dac=%h result=%h, required 00 00", dac_code, result);
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || sample !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: busy=%b sample=%b, required 0 0", busy, sample);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_known_sequence;
        logic [7:0] tbl [8] = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
        logic [7:0] ed;
        @(negedge clk);
        vin   = 8'h5A;
        start = 1'b1;
        sb.push_back(8'h5A);
        @(posedge clk);
        for (int j = 0; j <= 11; j++) begin
            @(negedge clk);
            start = 1'b0;
            ed = (j >= 2 && j <= 9) ? tbl[j-2] : 8'h00;
            n_vec++;
            if (dac_code !== ed) begin
                n_err++;
                $display("FAIL seq_dac j=%0d: got %h, required %h", j, dac_code, ed);
            end
            n_vec++;
            if (sample !== (j < 2) || busy !== (j <= 10) || done !== (j == 10)) begin
                n_err++;
                $display("FAIL seq_ctrl j=%0d: sample/busy/done=%b%b%b, required %b%b%b",
                         j, sample, busy, done, (j < 2), (j <= 10), (j == 10));
            end
        end
    endtask

    task automatic test_extremes;
        logic [7:0] vals [2] = '{8'h00, 8'hFF};
        int d0;
        for (int v = 0; v < 2; v++) begin
            d0 = done_cnt;
            @(negedge clk);
            vin   = vals[v];
            start = 1'b1;
            sb.push_back(vals[v]);
            @(posedge clk);
            for (int j = 0; j <= 11; j++) begin
                @(negedge clk);
                start = 1'b0;
                if (j >= 9) begin
                    n_vec++;
                    if (done !== (j == 10)) begin
                        n_err++;
                        $display("FAIL ext_latency v=%h j=%0d: done=%b, required %b",
                                 vals[v], j, done, (j == 10));
                    end
                end
                if (j == 10) begin
                    n_vec++;
                    if (result !== vals[v]) begin
                        n_err++;
                        $display("FAIL ext_result: got %h, required %h", result, vals[v]);
                    end
                end
            end
            n_vec++;
            if (done_cnt - d0 != 1) begin
                n_err++;
                $display("FAIL ext_done_count v=%h: got %0d, required 1", vals[v], done_cnt - d0);
            end
        end
    endtask

    task automatic test_start_ignored;
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        vin   = 8'h77;
        start = 1'b1;
        sb.push_back(8'h77);
        @(posedge clk);
        for (int j = 0; j <= 24; j++) begin
            @(negedge clk);
            start = (j == 4 || j == 5);
            n_vec++;
            if (busy !== (j <= 10)) begin
                n_err++;
                $display("FAIL ign_busy j=%0d: got %b, required %b", j, busy, (j <= 10));
            end
        end
        n_vec++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL ign_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid;
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        vin   = 8'hA5;
        start = 1'b1;
        sb.push_back(8'hA5);
        @(posedge clk);
        for (int j = 0; j <= 6; j++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_vec++;
        if (dac_code !== 8'hA8) begin
            n_err++;
            $display("FAIL rmid_bit3: dac=%h, required a8", dac_code);
        end
        #2;
        rst = 1'b0;
        #1;
        sb.delete();
        n_vec++;
        if ({sample, busy, done} !== 3'b000 || dac_code !== 8'h00 || result !== 8'h00) begin
            n_err++;
            $display("FAIL rmid_async: s/b/d=%b dac=%h result=%h, required 000 00 00",
                     {sample, busy, done}, dac_code, result);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || done_cnt != d0) begin
            n_err++;
            $display("FAIL rmid_hold: busy=%b dones=%0d, required 0 0", busy, done_cnt - d0);
        end
        rst   = 1'b1;
        vin   = 8'h3C;
        start = 1'b1;
        sb.push_back(8'h3C);
        @(posedge clk);
        for (int j = 0; j <= 11; j++) begin
            @(negedge clk);
            start = 1'b0;
            if (j == 10) begin
                n_vec++;
                if (done !== 1'b1 || result !== 8'h3C) begin
                    n_err++;
                    $display("FAIL rmid_after: done=%b result=%h, required 1 3c", done, result);
                end
            end
        end
        n_vec++;
        if (done_cnt - d0 != 1) begin
            n_err++;
            $display("FAIL rmid_done_count: got %0d, required 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] vals [3] = '{8'h33, 8'hC4, 8'h01};
        int t [3];
        int nd;
        nd = 0;
        @(negedge clk);
        vin   = vals[0];
        start = 1'b1;
        sb.push_back(vals[0]);
        @(posedge clk);
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (done === 1'b1 && nd < 3) begin
                t[nd] = j;
                nd++;
                if (nd < 3) begin
                    vin = vals[nd];
                    sb.push_back(vals[nd]);
                end else begin
                    start = 1'b0;
                end
            end
            if (j == 15) begin
                n_vec++;
                if (result !== 8'h33) begin
                    n_err++;
                    $display("FAIL b2b_hold: result=%h, required 33", result);
                end
            end
        end
        start = 1'b0;
        n_vec++;
        if (nd != 3) begin
            n_err++;
            $display("FAIL b2b_count: got %0d dones, required 3", nd);
        end else begin
            n_vec++;
            if (t[0] != 10 || t[1] - t[0] != 12 || t[2] - t[1] != 12) begin
                n_err++;
                $display("FAIL b2b_spacing: at %0d,%0d,%0d, required 10,22,34", t[0], t[1], t[2]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_sequence();
        test_extremes();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d codes never completed, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 Parameter WIDTH, 8, conversion resolution in bits (legal range 2..16).
REQ-002 Parameter SAMPLE_CYCLES, 2, number of clk cycles the sample switch is held closed (legal range 1..15).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = in reset).
REQ-005 start  input  1  conversion request, sampled in IDLE only.
REQ-006 comp  input  1  comparator decision: 1 = Vin >= DAC voltage for the current dac_code.
REQ-007 sample  output  1  sample/hold switch enable.
REQ-008 dac_code  output  WIDTH  trial code driven to the capacitive DAC.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle pulse; result is valid in that cycle.
REQ-011 result  output  WIDTH  last completed conversion code.

Function
REQ-012 FSM states: IDLE, SAMPLE, CONVERT, DONE.
REQ-013 IDLE -> SAMPLE on a rising edge with start=1; otherwise the FSM stays in IDLE.
REQ-014 SAMPLE lasts exactly SAMPLE_CYCLES cycles with sample=1; sample=0 in all other states.
REQ-015 SAMPLE -> CONVERT after SAMPLE_CYCLES cycles; the bit pointer is initialised to WIDTH-1.
REQ-016 CONVERT lasts exactly WIDTH cycles, one per bit from MSB to LSB.
- In the cycle for bit k, dac_code = (bits already decided) | (1<<k).
REQ-017 At the rising edge ending the bit-k cycle, bit k is kept if comp=1 and cleared if comp=0.
REQ-018 After the bit-0 decision, the FSM goes CONVERT -> DONE.
- result is loaded with the final code on that same edge.
REQ-019 DONE lasts exactly one cycle with done=1, then the FSM goes unconditionally to IDLE.
REQ-020 dac_code = 0 in IDLE, SAMPLE and DONE.
REQ-021 Latency: with start sampled at edge E0, done=1 during the cycle after edge E(SAMPLE_CYCLES+WIDTH).
- For the default parameters, that is 11 cycles after E0.
REQ-022 start in SAMPLE, CONVERT or DONE is ignored and not queued.
- start held high continuously yields back-to-back conversions separated by one IDLE cycle.
REQ-023 result holds its value from one DONE to the next and is not cleared by a new start.
REQ-024 comp is used only at the edge ending a CONVERT cycle; its value at all other times has no effect.
REQ-025 All outputs are driven directly from registers; there is no combinational path from start or comp to any output.

Reset
REQ-026 While rst=0, the FSM is IDLE and sample=0, dac_code=0, busy=0, done=0, result=0, bit pointer=WIDTH-1, cycle counter=0.
REQ-027 Asserting rst mid-conversion forces the REQ-026 values immediately, without waiting for clk.
- The partial code is discarded and done does not pulse.
REQ-028 After rst deasserts, the first rising edge evaluates IDLE normally; start=1 at that edge begins a conversion.

Structure
REQ-029 Package sar_pkg holds the FSM state enum, default WIDTH/SAMPLE_CYCLES constants, and counter-width helpers.
REQ-030 Single module, no sub-module.
- Bit pointer and sample counter are local registers.
- The successive-approximation register is one WIDTH-bit register plus a one-hot mask.

Verification
REQ-031 Use the team clock/reset generator with reset polarity set to active-low; use a behavioural comparator with comp = (Vin >= dac_code).
REQ-032 Vin=0x5A, WIDTH=8 -> dac_code sequence 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A,0x5B; result=0x5A; done one cycle.
REQ-033 Vin=0x00 -> result 0x00; Vin=0xFF -> result 0xFF; done exactly 11 cycles after the start edge in both cases.
REQ-034 start pulsed again during CONVERT -> no effect; exactly one done; busy stays high until DONE ends.
REQ-035 rst driven low mid-cycle during bit 3 of CONVERT -> all outputs reach reset values before the next clk edge; no done.
- A new conversion after release of rst completes correctly.
REQ-036 start held high for 3 conversions with Vin=0x33,0xC4,0x01 -> three done pulses 12 cycles apart; results 0x33,0xC4,0x01.
